nes_controller_port: RTL and testbench

- CPU-bus responder for the 2A03 joypad registers $4016/$4017, i.e. the peripheral end of the cpu_2a03 address/data/rw bus.
- Decodes CPU writes to $4016 into the controller strobe/latch line.
- Decodes CPU reads of $4016/$4017 into read data and a per-port serial clock pulse toward the external 4021-style shift registers.
- Sits on the CPU bus next to system RAM; its read data is muxed onto the CPU data bus by the top level.

---
 rtl/nes_bus_pkg.sv | 21 ++
 rtl/ctrl_clk_pulse.sv | 63 ++++++
 rtl/nes_controller_port.sv | 79 +++++++
 tb/tb_nes_controller_port.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus constants and helpers for the 2A03 joypad register block.
// Latency: n/a (package). Backpressure: n/a.
// Address/rw encodings, pulse state encoding, read-byte formatting.
package nes_bus_pkg;

    localparam logic [15:0] ADDR_JOY1 = 16'h4016;
    localparam logic [15:0] ADDR_JOY2 = 16'h4017;
    localparam logic        RW_READ   = 1'b1;
    localparam logic        RW_WRITE  = 1'b0;

    typedef enum logic {
        PULSE_IDLE = 1'b0,
        PULSE_LOW  = 1'b1
    } pulse_state_t;

    // Only bits 7:5 of the open-bus value survive; bit 0 carries the button.
    function automatic logic [7:0] joy_read_byte(input logic [7:0] open_bus, input logic btn);
        return {open_bus[7:5], 4'b0000, btn};
    endfunction

endpackage

// File: rtl/ctrl_clk_pulse.sv
// One controller port: ndata synchronizer plus the active-low serial clock pulse.
// Latency: data_bit is 2 cycles behind ndata; nclk falls on the edge after read_hit.
// Backpressure: none; a hit during a pulse reloads the counter and stretches it.
module ctrl_clk_pulse
    import nes_bus_pkg::*;
#(
    parameter int unsigned CLK_LOW_CYCLES = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic read_hit,
    input  logic ndata,
    output logic nclk,
    output logic data_bit
);

    localparam logic [3:0] RELOAD = 4'(CLK_LOW_CYCLES - 1);

    logic         ndata_meta;
    logic         ndata_sync;
    logic [3:0]   count;
    pulse_state_t state;

    always_ff @(posedge clock) begin
        if (reset) begin
            ndata_meta <= 1'b1;
            ndata_sync <= 1'b1;
        end else begin
            ndata_meta <= ndata;
            ndata_sync <= ndata_meta;
        end
    end

    assign data_bit = ~ndata_sync;

    // The rising edge of nclk is the controller's shift; a reload never adds one.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= PULSE_IDLE;
            nclk  <= 1'b1;
            count <= 4'd0;
        end else if (read_hit) begin
            state <= PULSE_LOW;
            nclk  <= 1'b0;
            count <= RELOAD;
        end else begin
            case (state)
                PULSE_LOW: begin
                    if (count == 4'd0) begin
                        state <= PULSE_IDLE;
                        nclk  <= 1'b1;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    nclk <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/nes_controller_port.sv
// CPU-bus responder for the $4016/$4017 joypad registers (strobe, read data, serial clocks).
// Latency: 1 cycle from a read hit to data_out/data_oe; strobe updates 1 cycle after the write.
// Backpressure: none; every qualified bus cycle is serviced, back-to-back included.
module nes_controller_port
    import nes_bus_pkg::*;
#(
    parameter int unsigned CLK_LOW_CYCLES = 6,
    parameter logic [7:0]  OPEN_BUS       = 8'h40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cyc_en,
    input  logic [15:0] addr,
    input  logic        rw,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        out_latch,
    output logic        nclk1,
    output logic        nclk2,
    input  logic        ndata1,
    input  logic        ndata2
);

    logic write_hit;
    logic read_hit1;
    logic read_hit2;
    logic bit1;
    logic bit2;
    logic unused_data_in;

    // $4017 writes belong to the APU frame counter and are deliberately not decoded.
    assign write_hit = cyc_en && (rw == RW_WRITE) && (addr == ADDR_JOY1);
    assign read_hit1 = cyc_en && (rw == RW_READ)  && (addr == ADDR_JOY1);
    assign read_hit2 = cyc_en && (rw == RW_READ)  && (addr == ADDR_JOY2);
    assign unused_data_in = ^data_in[7:1];

    ctrl_clk_pulse #(
        .CLK_LOW_CYCLES(CLK_LOW_CYCLES)
    ) u_port1 (
        .clock    (clock),
        .reset    (reset),
        .read_hit (read_hit1),
        .ndata    (ndata1),
        .nclk     (nclk1),
        .data_bit (bit1)
    );

    ctrl_clk_pulse #(
        .CLK_LOW_CYCLES(CLK_LOW_CYCLES)
    ) u_port2 (
        .clock    (clock),
        .reset    (reset),
        .read_hit (read_hit2),
        .ndata    (ndata2),
        .nclk     (nclk2),
        .data_bit (bit2)
    );

    // Read data reflects the bit present before this read's own shift pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
            out_latch <= 1'b0;
        end else begin
            data_oe <= read_hit1 || read_hit2;
            if (write_hit) begin
                out_latch <= data_in[0];
            end
            if (read_hit1) begin
                data_out <= joy_read_byte(OPEN_BUS, bit1);
            end else if (read_hit2) begin
                data_out <= joy_read_byte(OPEN_BUS, bit2);
            end
        end
    end

endmodule

// File: tb/tb_nes_controller_port.sv
// Bench for nes_controller_port: 4021 controller models on both ports, scoreboarded reads and pulse widths.
module tb_nes_controller_port;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cyc_en = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic        rw = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        out_latch;
    logic        nclk1;
    logic        nclk2;
    logic        ndata1;
    logic        ndata2;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] exp_data[$];
    int         exp_w1[$];
    int         exp_w2[$];
    int         low1 = 0;
    int         low2 = 0;

    // Reference model state: button bytes, strobe level, reads consumed since strobe.
    logic [7:0] btn1 = 8'hA5;
    logic [7:0] btn2 = 8'h80;
    logic       latch_m = 1'b0;
    int         k1 = 0;
    int         k2 = 0;
    logic       last_bit = 1'b0;

    // External 4021 shift registers (environment, not reference).
    logic [7:0] sr1 = 8'hFF;
    logic [7:0] sr2 = 8'hFF;
    logic       prev1 = 1'b1;
    logic       prev2 = 1'b1;

    nes_controller_port dut (
        .clock     (clock),
        .reset     (reset),
        .cyc_en    (cyc_en),
        .addr      (addr),
        .rw        (rw),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .out_latch (out_latch),
        .nclk1     (nclk1),
        .nclk2     (nclk2),
        .ndata1    (ndata1),
        .ndata2    (ndata2)
    );

    always #5 clock = ~clock;

    assign ndata1 = ~sr1[7];
    assign ndata2 = ~sr2[7];

    always @(posedge clock) begin
        prev1 <= nclk1;
        prev2 <= nclk2;
        if (out_latch === 1'b1) begin
            sr1 <= btn1;
            sr2 <= btn2;
        end else begin
            if (nclk1 === 1'b1 && prev1 === 1'b0) sr1 <= {sr1[6:0], 1'b1};
            if (nclk2 === 1'b1 && prev2 === 1'b0) sr2 <= {sr2[6:0], 1'b1};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_bit(input int port, input bit advance);
        logic [7:0] b;
        int         k;
        logic       r;
        b = (port == 1) ? btn1 : btn2;
        k = (port == 1) ? k1 : k2;
        if (latch_m)    r = b[7];
        else if (k < 8) r = b[7-k];
        else            r = 1'b1;
        if (advance && !latch_m) begin
            if (port == 1) k1++;
            else           k2++;
        end
        return r;
    endfunction

    task automatic bus_cycle(input logic [15:0] a, input logic r, input logic [7:0] d, input logic en);
        @(posedge clock);
        #1;
        cyc_en = en; addr = a; rw = r; data_in = d;
        @(posedge clock);
        #1;
        cyc_en = 1'b0; addr = 16'h0000; rw = 1'b1; data_in = 8'h00;
    endtask

    // width = expected low time of the pulse started here; 0 when this read only stretches one.
    task automatic do_read(input int port, input bit stretch, input int width);
        logic b;
        if (stretch) b = last_bit;
        else         b = ref_bit(port, 1'b1);
        last_bit = b;
        exp_data.push_back({3'b010, 4'b0000, b});
        if (width > 0) begin
            if (port == 1) exp_w1.push_back(width);
            else           exp_w2.push_back(width);
        end
        bus_cycle((port == 1) ? 16'h4016 : 16'h4017, 1'b1, 8'h00, 1'b1);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        bus_cycle(a, 1'b0, d, 1'b1);
        if (a == 16'h4016) begin
            latch_m = d[0];
            if (d[0]) begin
                k1 = 0;
                k2 = 0;
            end
        end
        chk("out_latch_after_write", {31'd0, out_latch}, {31'd0, latch_m});
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clock);
    endtask

    // Monitor: pops read data on data_oe and low-pulse widths on each nclk rise.
    always @(negedge clock) begin
        if (data_oe === 1'b1) begin
            if (exp_data.size() == 0) chk("unexpected_data_oe", 32'd1, 32'd0);
            else                      chk("data_out", {24'd0, data_out}, {24'd0, exp_data.pop_front()});
        end
        if (nclk1 === 1'b0) begin
            low1++;
        end else if (low1 > 0) begin
            if (exp_w1.size() == 0) chk("unexpected_nclk1_pulse", low1, 0);
            else                    chk("nclk1_low_width", low1, exp_w1.pop_front());
            low1 = 0;
        end
        if (nclk2 === 1'b0) begin
            low2++;
        end else if (low2 > 0) begin
            if (exp_w2.size() == 0) chk("unexpected_nclk2_pulse", low2, 0);
            else                    chk("nclk2_low_width", low2, exp_w2.pop_front());
            low2 = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a;
        int          op;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset_out_latch", {31'd0, out_latch}, 32'd0);
        chk("reset_nclk1", {31'd0, nclk1}, 32'd1);
        chk("reset_nclk2", {31'd0, nclk2}, 32'd1);
        chk("reset_data_oe", {31'd0, data_oe}, 32'd0);
        chk("reset_data_out", {24'd0, data_out}, 32'd0);

        // Strobe loads both controllers: port 1 = A5, port 2 = 80.
        do_write(16'h4016, 8'h01);
        gap(3);
        do_write(16'h4016, 8'h00);
        gap(10);

        for (int i = 0; i < 8; i++) begin
            do_read(1, 1'b0, 6);
            gap(10);
        end
        chk("nclk2_idle_after_port1", {31'd0, nclk2}, 32'd1);

        do_read(2, 1'b0, 6);
        gap(10);

        // Second read two cycles after the first stretches a single pulse to 8 cycles.
        do_read(1, 1'b0, 8);
        do_read(1, 1'b1, 0);
        gap(12);

        // Reset three cycles into a pulse.
        do_read(1, 1'b0, 3);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        gap(3);
        #1;
        reset = 1'b0;
        chk("midpulse_reset_nclk1", {31'd0, nclk1}, 32'd1);
        chk("midpulse_reset_data_out", {24'd0, data_out}, 32'd0);
        chk("midpulse_reset_out_latch", {31'd0, out_latch}, 32'd0);
        gap(10);
        do_read(1, 1'b0, 6);
        gap(10);

        // Non-hits: other address, $4017 write, unqualified cycle.
        bus_cycle(16'h4015, 1'b1, 8'h00, 1'b1);
        gap(3);
        do_write(16'h4017, 8'hFF);
        bus_cycle(16'h4016, 1'b1, 8'h00, 1'b0);
        bus_cycle(16'h4016, 1'b0, 8'hFF, 1'b0);
        gap(10);
        chk("nonhit_out_latch", {31'd0, out_latch}, 32'd0);
        chk("nonhit_nclk1", {31'd0, nclk1}, 32'd1);
        chk("nonhit_nclk2", {31'd0, nclk2}, 32'd1);

        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                do_read(1, 1'b0, 6);
            end else if (op <= 6) begin
                do_read(2, 1'b0, 6);
            end else if (op == 7) begin
                btn1 = 8'($urandom);
                btn2 = 8'($urandom);
                do_write(16'h4016, {7'($urandom), 1'b1});
                gap($urandom_range(1, 4));
                do_write(16'h4016, {7'($urandom), 1'b0});
            end else if (op == 8) begin
                do_write(16'h4017, 8'($urandom));
            end else begin
                a = 16'($urandom);
                if (a == 16'h4016 || a == 16'h4017) a = 16'h4015;
                bus_cycle(a, 1'($urandom), 8'($urandom), 1'b1);
            end
            gap(10 + $urandom_range(0, 4));
        end

        gap(20);
        chk("pending_reads", exp_data.size(), 32'd0);
        chk("pending_nclk1_pulses", exp_w1.size(), 32'd0);
        chk("pending_nclk2_pulses", exp_w2.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
